// File: rtl/sync_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sync_debounce_pkg
//   Shared constants and helpers for the synchronise-and-debounce block.
//   - SYNC_STAGES_MIN     : shallowest synchroniser chain considered safe.
//   - DEBOUNCE_CYCLES_MIN : smallest legal debounce window.
//   - cnt_width(n)        : bits needed to hold values 0..n.
// ---------------------------------------------------------------------------
package sync_debounce_pkg;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int DEBOUNCE_CYCLES_MIN = 1;

    // Width of a counter that must represent 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : sync_debounce_pkg

// File: rtl/bit_sync_chain.sv
// ---------------------------------------------------------------------------
// bit_sync_chain
//   Single-bit synchroniser: STAGES asynchronously reset flops in series.
//   Reusable by any block that has to bring a level into the CLK domain.
// Parameters
//   STAGES     depth of the chain (>= SYNC_STAGES_MIN)
//   RESET_VAL  value loaded into every stage while RST is high
// Ports
//   CLK  input   sampling clock
//   RST  input   asynchronous, active-high reset
//   D    input   asynchronous level
//   Q    output  last stage of the chain
// ---------------------------------------------------------------------------
module bit_sync_chain
    import sync_debounce_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("bit_sync_chain: STAGES must be >= %0d", SYNC_STAGES_MIN);
    end

    logic [STAGES-1:0] sync_r;

    // Shift the raw level through the chain; bit 0 is the metastability catcher.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], D};
        end
    end

    assign Q = sync_r[STAGES-1];

endmodule : bit_sync_chain

// File: rtl/sync_debounce_q.sv
// ---------------------------------------------------------------------------
// sync_debounce_q
//   Synchronises a raw asynchronous level and debounces it before it feeds a
//   downstream flop. Q only changes after the synchronised level has differed
//   from Q for DEBOUNCE_CYCLES consecutive rising edges of CLK.
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive mismatching edges to accept a change (>= 1)
//   RESET_VAL        value of the chain and Q during/after reset
// Ports
//   CLK   input   single clock
//   RST   input   asynchronous, active-high reset
//   D     input   raw asynchronous level
//   Q     output  synchronised, debounced level (registered)
//   RISE  output  one-cycle pulse in the cycle Q goes 0->1
//   FALL  output  one-cycle pulse in the cycle Q goes 1->0
//   BUSY  output  registered, high while a candidate change is being counted
// Configuration
//   SYNC_DEBOUNCE_EDGE_EN : when defined, RISE/FALL are built as registered
//                           pulses; otherwise they are tied low and no edge
//                           flops exist. Q/BUSY timing is unaffected.
// ---------------------------------------------------------------------------
module sync_debounce_q
    import sync_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_debounce
        $error("sync_debounce_q: DEBOUNCE_CYCLES must be >= %0d", DEBOUNCE_CYCLES_MIN);
    end

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s_s;
    logic             q_r;
    logic             q_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;

    bit_sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (D),
        .Q   (s_s)
    );

    // Debounce filter: count consecutive mismatches, accept on the last one.
    // The final else only catches an unknown s in simulation (both equality
    // tests come out false), so Q never picks up an X.
    always_comb begin
        cnt_nxt_s = CNT_ZERO;
        q_nxt_s   = q_r;
        if (s_s == q_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (s_s != q_r) begin
            if (cnt_r == CNT_LAST) begin
                q_nxt_s   = s_s;
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = CNT_ZERO;
        end
    end

    // Filter state, debounced output and busy flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_r    <= RESET_VAL;
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            cnt_r  <= cnt_nxt_s;
            busy_r <= (cnt_nxt_s != CNT_ZERO);
        end
    end

    assign Q    = q_r;
    assign BUSY = busy_r;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses line up with the cycle Q takes its new value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= q_nxt_s & ~q_r;
            fall_r <= ~q_nxt_s & q_r;
        end
    end

    assign RISE = rise_r;
    assign FALL = fall_r;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

endmodule : sync_debounce_q

// File: tb/tb_sync_debounce_q.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce_q
//   Directed bench for sync_debounce_q. Instance A uses the defaults
//   (2 stages, 4 cycles, reset 0); instance B uses 1 debounce cycle with
//   reset value 1. Expected values are hand-derived per edge.
// ---------------------------------------------------------------------------
module tb_sync_debounce_q;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic d_a, q_a, rise_a, fall_a, busy_a;
    logic d_b, q_b, rise_b, fall_b, busy_b;

    int n_vec;
    int n_miss;

    sync_debounce_q #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (1'b0)
    ) u_dut_a (
        .CLK  (clk),
        .RST  (rst),
        .D    (d_a),
        .Q    (q_a),
        .RISE (rise_a),
        .FALL (fall_a),
        .BUSY (busy_a)
    );

    sync_debounce_q #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .RESET_VAL       (1'b1)
    ) u_dut_b (
        .CLK  (clk),
        .RST  (rst),
        .D    (d_b),
        .Q    (q_b),
        .RISE (rise_b),
        .FALL (fall_b),
        .BUSY (busy_b)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a clean step on instance A just after an edge (edge 0) and check
    // the 7 following edges: accept at edge 6, BUSY over edges 3..5.
    task automatic step_a(input string tag, input logic nd);
        logic exp_q;
        d_a = nd;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_q = (k >= 6) ? nd : ~nd;
            chk($sformatf("%s q e%0d", tag, k), q_a, exp_q);
            chk($sformatf("%s busy e%0d", tag, k), busy_a, (k >= 3 && k <= 5));
            chk($sformatf("%s rise e%0d", tag, k), rise_a, EDGE_EN && (k == 6) && nd);
            chk($sformatf("%s fall e%0d", tag, k), fall_a, EDGE_EN && (k == 6) && !nd);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b0;
        d_a    = 1'b1;
        d_b    = 1'b1;

        // Reset asserted between edges must act without any clock edge.
        #1;
        rst = 1'b1;
        #1;
        chk("rst q_a", q_a, 1'b0);
        chk("rst busy_a", busy_a, 1'b0);
        chk("rst rise_a", rise_a, 1'b0);
        chk("rst fall_a", fall_a, 1'b0);
        chk("rst q_b", q_b, 1'b1);
        chk("rst busy_b", busy_b, 1'b0);

        // Hold reset over a few edges, then release just after an edge with D=1.
        tick();
        tick();
        chk("rst hold q_a", q_a, 1'b0);
        rst = 1'b0;
        step_a("release", 1'b1);

        // Clean falling step on the default instance.
        step_a("fall", 1'b0);

        // Clean rising step on the default instance.
        step_a("rise", 1'b1);
        step_a("back", 1'b0);

        // Glitch: D high for 3 cycles, s mismatches for only 3 edges.
        d_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                d_a = 1'b0;
            end
            tick();
            chk($sformatf("glitch q e%0d", k), q_a, 1'b0);
            chk($sformatf("glitch rise e%0d", k), rise_a, 1'b0);
            chk($sformatf("glitch busy e%0d", k), busy_a, (k >= 3 && k <= 5));
        end

        // Reset mid-count: cnt reaches 2 after edge 4, then reset mid-cycle.
        d_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        chk("mid busy before", busy_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst q", q_a, 1'b0);
        chk("mid rst busy", busy_a, 1'b0);
        tick();
        rst = 1'b0;
        step_a("mid release", 1'b1);

        // Instance B: Q=1 from reset, D 1->0, one debounce cycle.
        chk("b pre q", q_b, 1'b1);
        d_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("b q e%0d", k), q_b, (k < 3));
            chk($sformatf("b fall e%0d", k), fall_b, EDGE_EN && (k == 3));
            chk($sformatf("b rise e%0d", k), rise_b, 1'b0);
            chk($sformatf("b busy e%0d", k), busy_b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_sync_debounce_q
